// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered and held on the ALU for ALU_LAT cycles. The result and
// flags are then captured into a response register and returned over a
// valid/ready channel, tagged with the requester ID.
module alu_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_A,
  input  logic [2*WIDTH-1:0] req_B,
  input  logic [5:0]         req_cntrl,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic [2:0]         alu_cntrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_carry_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags
);

  localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             last_grant_reg;
  logic             owner_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic [2:0]       alu_cntrl_reg;
  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic [3:0]       rsp_flags_reg;

  // Per-requester views of the packed request buses
  logic [WIDTH-1:0] lane_a     [2];
  logic [WIDTH-1:0] lane_b     [2];
  logic [2:0]       lane_cntrl [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_a[gi]     = req_A[gi*WIDTH +: WIDTH];
    assign lane_b[gi]     = req_B[gi*WIDTH +: WIDTH];
    assign lane_cntrl[gi] = req_cntrl[gi*3 +: 3];
  end

  // Grant: the lone valid requester, or on a tie the one that did not win last
  logic grant_any;
  logic grant_id;
  logic cnt_zero;

  assign grant_any = |req_valid;
  assign grant_id  = (&req_valid) ? ~last_grant_reg : req_valid[1];
  assign cnt_zero  = (cnt_reg == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    if (cnt_zero)  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accept strobe: only in IDLE, only for the granted requester, never during reset
  always_comb begin
    req_ready = 2'b00;
    if (reset && (state_reg == IDLE) && grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Operand capture, latency counter and response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cnt_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_cntrl_reg  <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            alu_a_reg      <= lane_a[grant_id];
            alu_b_reg      <= lane_b[grant_id];
            alu_cntrl_reg  <= lane_cntrl[grant_id];
            owner_reg      <= grant_id;
            last_grant_reg <= grant_id;
            cnt_reg        <= CNT_LOAD;
          end
        end
        EXEC: begin
          if (cnt_zero) begin
            rsp_result_reg <= alu_result;
            rsp_flags_reg  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
            rsp_id_reg     <= owner_reg;
            rsp_valid_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_A      = alu_a_reg;
  assign alu_B      = alu_b_reg;
  assign alu_cntrl  = alu_cntrl_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flags  = rsp_flags_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. Two instances are built, with ALU_LAT=1 and
// ALU_LAT=3, and each one drives a behavioural ALU. The bench applies a vector
// table, then random single ops, then hand-written sequences for contention,
// backpressure and an asynchronous reset that arrives mid-operation.
module tb_alu_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid  [2];
  logic [1:0]   req_ready  [2];
  logic [127:0] req_A      [2];
  logic [127:0] req_B      [2];
  logic [5:0]   req_cntrl  [2];
  logic [63:0]  alu_A      [2];
  logic [63:0]  alu_B      [2];
  logic [2:0]   alu_cntrl  [2];
  logic         rsp_valid  [2];
  logic         rsp_ready  [2];
  logic         rsp_id     [2];
  logic [63:0]  rsp_result [2];
  logic [3:0]   rsp_flags  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {result, N, Z, V, C}. Undefined ops return A.
  function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] op);
    logic [64:0] wide;
    logic [63:0] r;
    logic        v;
    logic        c;
    wide = '0;
    v    = 1'b0;
    c    = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[63:0];
        c    = wide[64];
        v    = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        wide = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r    = wide[63:0];
        c    = wide[64];
        v    = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      default: r = a;
    endcase
    return {r, r[63], (r == 64'd0), v, c};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [67:0] alu_out;
    assign alu_out = alu_model(alu_A[gi], alu_B[gi], alu_cntrl[gi]);

    alu_share_arbiter #(
      .WIDTH  (64),
      .ALU_LAT((gi == 0) ? 1 : 3)
    ) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .req_valid    (req_valid[gi]),
      .req_ready    (req_ready[gi]),
      .req_A        (req_A[gi]),
      .req_B        (req_B[gi]),
      .req_cntrl    (req_cntrl[gi]),
      .alu_A        (alu_A[gi]),
      .alu_B        (alu_B[gi]),
      .alu_cntrl    (alu_cntrl[gi]),
      .alu_result   (alu_out[67:4]),
      .alu_negative (alu_out[3]),
      .alu_zero     (alu_out[2]),
      .alu_overflow (alu_out[1]),
      .alu_carry_out(alu_out[0]),
      .rsp_valid    (rsp_valid[gi]),
      .rsp_ready    (rsp_ready[gi]),
      .rsp_id       (rsp_id[gi]),
      .rsp_result   (rsp_result[gi]),
      .rsp_flags    (rsp_flags[gi])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input int i, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    req_A[k][i*64 +: 64]   = a;
    req_B[k][i*64 +: 64]   = b;
    req_cntrl[k][i*3 +: 3] = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) at negedge+1 sample points until a response is valid
  task automatic wait_rsp(input int k);
    int c;
    c = 0;
    while (!rsp_valid[k] && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("rsp_arrived", rsp_valid[k], 1'b1);
  endtask

  // One op from one requester, with checks on accept, operand hold, latency and response
  task automatic run_single(input int k, input int id, input logic [2:0] op,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] er, input logic [3:0] ef, input string tag);
    int         c;
    logic [1:0] onehot;
    onehot = (id == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(k, id, op, a, b);
    req_valid[k] = onehot;
    rsp_ready[k] = 1'b1;
    #1 check({tag, "_ready"}, req_ready[k], onehot);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 2'b00;
    set_req(k, id, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    #1;
    check({tag, "_ready_exec"}, req_ready[k], 2'b00);
    check({tag, "_alu_cntrl"}, alu_cntrl[k], op);
    c = 1;
    while (!rsp_valid[k] && c < 20) begin
      check({tag, "_alu_A_hold"}, alu_A[k], a);
      check({tag, "_alu_B_hold"}, alu_B[k], b);
      @(negedge clk);
      #1;
      c++;
    end
    check({tag, "_latency"}, c - 1, lat_of(k));
    check({tag, "_rsp_valid"}, rsp_valid[k], 1'b1);
    check({tag, "_result"}, rsp_result[k], er);
    check({tag, "_flags"}, rsp_flags[k], ef);
    check({tag, "_id"}, rsp_id[k], id[0]);
    $display("txn %s inst=%0d id=%0d op=%b A=%h B=%h result=%h flags=%b", tag, k, id, op, a,
             b, rsp_result[k], rsp_flags[k]);
    @(posedge clk);
    @(negedge clk);
    #1 check({tag, "_consumed"}, rsp_valid[k], 1'b0);
  endtask

  typedef struct {
    int          k;
    int          id;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [67:0] exp;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rop;
    int          rid;
    logic        exp_last;
    logic        exp_g;
    logic        pending;
    int          got;
    logic        expq [$];
    logic [63:0] snap_res;
    logic [3:0]  snap_flags;
    logic        snap_id;

    vecs[0]  = '{0, 0, 3'b110, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 64'hF00FF00FF00FF00F, 4'b1000};
    vecs[1]  = '{0, 1, 3'b110, 64'h123, 64'h123, 64'h0, 4'b0100};
    vecs[2]  = '{0, 1, 3'b010, 64'h7FFFFFFFFFFFFFFF, 64'h1, 64'h8000000000000000, 4'b1010};
    vecs[3]  = '{0, 0, 3'b011, 64'h5, 64'h3, 64'h2, 4'b0001};
    vecs[4]  = '{0, 0, 3'b011, 64'h3, 64'h5, 64'hFFFFFFFFFFFFFFFE, 4'b1000};
    vecs[5]  = '{1, 1, 3'b010, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 4'b0101};
    vecs[6]  = '{1, 0, 3'b100, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF000F000F000F000, 4'b1000};
    vecs[7]  = '{1, 1, 3'b101, 64'h00FF00FF00FF00FF, 64'h0000000000000F00, 64'h00FF00FF00FF0FFF, 4'b0000};
    vecs[8]  = '{0, 1, 3'b000, 64'hDEAD, 64'h0, 64'h0, 4'b0100};
    vecs[9]  = '{1, 0, 3'b111, 64'h55, 64'hAA, 64'h55, 4'b0000};
    vecs[10] = '{0, 0, 3'b011, 64'h8000000000000000, 64'h1, 64'h7FFFFFFFFFFFFFFF, 4'b0011};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b11;
      req_A[k]     = '0;
      req_B[k]     = '0;
      req_cntrl[k] = '0;
      rsp_ready[k] = 1'b0;
    end

    // Reset state with both requesters already valid
    #12;
    for (int k = 0; k < 2; k++) begin
      check("reset_req_ready", req_ready[k], 2'b00);
      check("reset_rsp_valid", rsp_valid[k], 1'b0);
      check("reset_alu_A", alu_A[k], 64'd0);
      check("reset_alu_cntrl", alu_cntrl[k], 3'd0);
      check("reset_rsp_result", rsp_result[k], 64'd0);
      check("reset_rsp_id", rsp_id[k], 1'b0);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) req_valid[k] = 2'b00;
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      run_single(vecs[i].k, vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].res, vecs[i].flags, $sformatf("vec%0d", i));
    end

    // Random single ops checked against the ALU reference
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 25; n++) begin
        rid = int'($urandom_range(0, 1));
        rop = 3'($urandom_range(0, 7));
        ra  = {$urandom, $urandom};
        rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
        exp = alu_model(ra, rb, rop);
        run_single(k, rid, rop, ra, rb, exp[67:4], exp[3:0], $sformatf("rnd%0d_%0d", k, n));
      end
    end

    // Contention: both valid continuously from reset, grants must alternate starting at 0
    for (int k = 0; k < 2; k++) req_valid[k] = 2'b00;
    do_reset();
    @(negedge clk);
    set_req(0, 0, 3'b010, 64'd5, 64'd3);
    set_req(0, 1, 3'b011, 64'd5, 64'd3);
    req_valid[0] = 2'b11;
    rsp_ready[0] = 1'b1;
    exp_last = 1'b1;
    pending  = 1'b0;
    got      = 0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      #1;
      if (req_ready[0] != 2'b00) begin
        check("alt_no_grant_busy", pending, 1'b0);
        exp_g = ~exp_last;
        check("alt_grant", req_ready[0], exp_g ? 2'b10 : 2'b01);
        exp_last = exp_g;
        pending  = 1'b1;
        expq.push_back(exp_g);
      end
      if (rsp_valid[0]) begin
        if (expq.size() == 0) begin
          check("alt_rsp_without_grant", 1'b1, 1'b0);
        end else begin
          check("alt_rsp_id", rsp_id[0], expq[0]);
          check("alt_rsp_result", rsp_result[0], expq[0] ? 64'd2 : 64'd8);
          $display("txn alt id=%0d result=%0d", rsp_id[0], rsp_result[0]);
          void'(expq.pop_front());
        end
        pending = 1'b0;
        got++;
      end
      @(negedge clk);
    end
    req_valid[0] = 2'b00;
    check("alt_rsp_count", got, 4);

    // Backpressure on instance with ALU_LAT=3; requester 1 stays pending meanwhile
    do_reset();
    @(negedge clk);
    set_req(1, 0, 3'b100, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00);
    set_req(1, 1, 3'b010, 64'd40, 64'd2);
    req_valid[1] = 2'b11;
    rsp_ready[1] = 1'b0;
    #1 check("bp_first_grant", req_ready[1], 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 2'b10;
    set_req(1, 0, 3'b110, 64'h1, 64'h2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_exec_alu_A", alu_A[1], 64'hF0F0F0F0F0F0F0F0);
      check("bp_exec_alu_B", alu_B[1], 64'hFF00FF00FF00FF00);
      check("bp_exec_alu_cntrl", alu_cntrl[1], 3'b100);
      check("bp_exec_ready", req_ready[1], 2'b00);
      check("bp_exec_rsp_valid", rsp_valid[1], 1'b0);
      @(negedge clk);
    end
    #1;
    check("bp_rsp_valid", rsp_valid[1], 1'b1);
    check("bp_rsp_result", rsp_result[1], 64'hF000F000F000F000);
    check("bp_rsp_flags", rsp_flags[1], 4'b1000);
    snap_res   = rsp_result[1];
    snap_flags = rsp_flags[1];
    snap_id    = rsp_id[1];
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", rsp_valid[1], 1'b1);
      check("bp_hold_result", rsp_result[1], snap_res);
      check("bp_hold_flags", rsp_flags[1], snap_flags);
      check("bp_hold_id", rsp_id[1], snap_id);
      check("bp_hold_ready", req_ready[1], 2'b00);
      @(negedge clk);
      #1;
    end
    $display("txn bp inst=1 id=%0d result=%h flags=%b", rsp_id[1], rsp_result[1], rsp_flags[1]);
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp_consumed_once", rsp_valid[1], 1'b0);
    check("bp_pending_grant", req_ready[1], 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 2'b00;
    #1;
    wait_rsp(1);
    check("bp_second_id", rsp_id[1], 1'b1);
    check("bp_second_result", rsp_result[1], 64'd42);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset mid-EXEC drops the op; requester 0 wins afterwards
    set_req(1, 1, 3'b010, 64'd1, 64'd2);
    req_valid[1] = 2'b10;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid[1], 1'b0);
    check("rst_alu_A", alu_A[1], 64'd0);
    check("rst_alu_B", alu_B[1], 64'd0);
    check("rst_alu_cntrl", alu_cntrl[1], 3'd0);
    set_req(1, 0, 3'b010, 64'd5, 64'd3);
    set_req(1, 1, 3'b011, 64'd5, 64'd3);
    req_valid[1] = 2'b11;
    #1 check("rst_req_ready", req_ready[1], 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_first_grant", req_ready[1], 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 2'b00;
    #1 check("rst_no_stale_rsp", rsp_valid[1], 1'b0);
    wait_rsp(1);
    check("rst_after_id", rsp_id[1], 1'b0);
    check("rst_after_result", rsp_result[1], 64'd8);
    $display("txn rst inst=1 id=%0d result=%0d", rsp_id[1], rsp_result[1]);
    @(posedge clk);
    @(negedge clk);
    #1 check("rst_after_consumed", rsp_valid[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
